decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Decode stage of the 5-stage core. Sits between Fetch and Issue.
//  - Consumes if_id_instruc and if_id_nextpc from Fetch.
//  - Reads the register bank and resolves branches and jumps.
//  - Drives the PC-redirect bus back to Fetch.
//  - Registers the decoded bundle for Issue.
//  - Propagates the Issue stall to Fetch and squashes the wrong-path slot after a redirect.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0040  illegal-opcode trap target; informational, Fetch hardcodes it
// PORTS
//  clock             in   1   single clock; all state on posedge
//  reset             in   1   asynchronous, active-low reset
//  if_id_instruc     in   32  instruction from Fetch
//  if_id_nextpc      in   32  PC base for target computation
//  iss_id_stall      in   1   Issue cannot accept a new bundle
//  id_stall          out  1   stall to Fetch; = iss_id_stall (combinational)
//  id_if_selpcsource out  1   redirect request
//  id_if_selpctype   out  2   00 branch, 01 JR (rega), 10 J (index), 11 trap
//  id_if_pcimd2ext   out  32  if_id_nextpc + (sext(instr[15:0]) << 2)
//  id_if_rega        out  32  reg_id_dataa (JR target)
//  id_if_pcindex     out  32  {if_id_nextpc[31:28], instr[25:0], 2'b00}
//  id_reg_addra      out  5   instr[25:21]; combinational read address A
//  id_reg_addrb      out  5   instr[20:16]; combinational read address B
//  reg_id_dataa      in   32  read data A (same cycle)
//  reg_id_datab      in   32  read data B (same cycle)
//  id_iss_valid      out  1   bundle valid
//  id_iss_op         out  6   opcode
//  id_iss_funct      out  6   funct
//  id_iss_rega       out  32  read data A
//  id_iss_regb       out  32  read data B
//  id_iss_imedext    out  32  sext(imm16); zext for ANDI/ORI/XORI; {imm16,16'h0} for LUI
//  id_iss_regdest    out  5   rd for R-type; rt for I-type and LW
//  id_iss_writereg   out  1   destination write enable
// BEHAVIOUR
//  Legal opcodes:
//  - R-type 000000: funct 001000 is JR; other functs pass to Issue.
//  - J 000010, BEQ 000100, BNE 000101.
//  - ADDI/ADDIU/SLTI/ANDI/ORI/XORI/LUI: 001000-001111, excluding 001011.
//  - LW 100011, SW 101011.
//  - Anything else is illegal.
//  Redirect outputs (combinational):
//  - selpcsource=1 only in RUN, with iss_id_stall=0, when the instruction is one of:
//    - BEQ with A==B (type 00), or BNE with A!=B (type 00);
//    - J (type 10) or JR (type 01);
//    - illegal with the trap enabled (type 11).
//  - Otherwise selpcsource=0 and selpctype=00. The target buses are always driven.
//  FSM, posedge, 2 states:
//  - RUN -> SQUASH when selpcsource=1.
//    Reason: Fetch loads the sequential (wrong-path) word on that same edge.
//  - SQUASH -> RUN on the first edge with iss_id_stall=0; the slot is bundled with valid=0.
//  - SQUASH holds while iss_id_stall=1.
//  Pipeline register:
//  - iss_id_stall=1: every id_iss_* output holds its value.
//  - iss_id_stall=0: load the new decode.
//    - valid = (state==RUN) & legal.
//    - J, JR, BEQ, BNE and SW load with writereg=0.
//  - Latency: Fetch output to Issue bundle = 1 cycle.
//  Boundary cases:
//  - Redirect and stall together: no redirect; retried next cycle with the same held instruction.
//  - Register $0 as destination: writereg forced to 0.
//  - Back-to-back taken branch: the second one is squashed and never redirects.
//  - Reset mid-operation: state=RUN, all id_iss_* = 0, valid=0.
//    Redirect outputs follow the combinational rules from the first cycle.
// CONFIGURATION
//  DECODE_ILLEGAL_TRAP_EN
//  - Defined: illegal opcode redirects with selpctype=11 and enters SQUASH; bundle valid=0.
//  - Undefined: illegal opcode is a bubble (valid=0) with no redirect and no state change.
// TESTING
//  1. Reset:
//     - Stimulus: reset=0 mid-stream.
//     - Response: id_iss_valid=0, all id_iss_*=0, FSM in RUN, selpcsource=0.
//  2. ADDI r2,r1,-4 with r1=5:
//     - Response next edge: valid=1, op=001000, rega=5, imedext=32'hFFFF_FFFC, regdest=2, writereg=1.
//  3. BEQ taken (nextpc=0x100, imm=3, A=B=7):
//     - Response: selpcsource=1, type 00, pcimd2ext=0x10C.
//     - The following slot emerges valid=0; the target instruction is valid.
//  4. BNE not taken (A=B), then J with index 0x10:
//     - Response: BNE gives no redirect.
//     - J gives type 10, pcindex=0x40; no write.
//  5. iss_id_stall=1 for 3 cycles during a JR:
//     - Response: id_stall=1, outputs held, no redirect.
//     - The cycle after release: type 01, id_if_rega=reg A.
//  6. Opcode 111111:
//     - With TRAP_EN: type 11 plus one squash.
//     - Without TRAP_EN: valid=0, no redirect.

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch/Decode/Issue/register-bank signal bundle around the decode stage.
// master = decode stage side, slave = surrounding pipeline side.
interface decode_stage_if;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        iss_id_stall;
    logic        id_stall;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic [4:0]  id_reg_addra;
    logic [4:0]  id_reg_addrb;
    logic [31:0] reg_id_dataa;
    logic [31:0] reg_id_datab;
    logic        id_iss_valid;
    logic [5:0]  id_iss_op;
    logic [5:0]  id_iss_funct;
    logic [31:0] id_iss_rega;
    logic [31:0] id_iss_regb;
    logic [31:0] id_iss_imedext;
    logic [4:0]  id_iss_regdest;
    logic        id_iss_writereg;

    modport master (
        input  if_id_instruc, if_id_nextpc, iss_id_stall, reg_id_dataa, reg_id_datab,
        output id_stall, id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
               id_if_rega, id_if_pcindex, id_reg_addra, id_reg_addrb,
               id_iss_valid, id_iss_op, id_iss_funct, id_iss_rega, id_iss_regb,
               id_iss_imedext, id_iss_regdest, id_iss_writereg
    );

    modport slave (
        output if_id_instruc, if_id_nextpc, iss_id_stall, reg_id_dataa, reg_id_datab,
        input  id_stall, id_if_selpcsource, id_if_selpctype, id_if_pcimd2ext,
               id_if_rega, id_if_pcindex, id_reg_addra, id_reg_addrb,
               id_iss_valid, id_iss_op, id_iss_funct, id_iss_rega, id_iss_regb,
               id_iss_imedext, id_iss_regdest, id_iss_writereg
    );
endinterface

// File: rtl/decode_stage.sv
// Decode stage: register read, branch/jump resolution, PC redirect, wrong-path squash.
// Optional macro DECODE_ILLEGAL_TRAP_EN: illegal opcodes redirect to the trap vector (0x40, owned by Fetch).
module decode_stage (
    input  logic           clock,
    input  logic           reset,
    decode_stage_if.master bus_io
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;
    localparam int unsigned RW   = 5;
    localparam int unsigned IMMW = 16;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_RSVD  = 6'b001011;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_XORI  = 6'b001110;
    localparam logic [OPW-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PC_BRANCH = 2'b00;
    localparam logic [1:0] PC_JR     = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

    state_t state_q;

    logic [OPW-1:0]  opcode;
    logic [OPW-1:0]  funct;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   rd;
    logic [IMMW-1:0] imm16;
    logic [XLEN-1:0] imm_sext;
    logic            stall;

    logic            is_rtype, is_jr, is_j, is_beq, is_bne, is_alui, is_lw, is_sw;
    logic            legal_c, writes_c, regs_eq_c, take_c;
    logic [1:0]      selpctype_c;
    logic [XLEN-1:0] imedext_d;
    logic [RW-1:0]   regdest_d;
    logic            valid_d, writereg_d;

    logic            valid_q, writereg_q;
    logic [OPW-1:0]  op_q, funct_q;
    logic [XLEN-1:0] rega_q, regb_q, imedext_q;
    logic [RW-1:0]   regdest_q;

    assign opcode   = bus_io.if_id_instruc[31:26];
    assign rs       = bus_io.if_id_instruc[25:21];
    assign rt       = bus_io.if_id_instruc[20:16];
    assign rd       = bus_io.if_id_instruc[15:11];
    assign funct    = bus_io.if_id_instruc[5:0];
    assign imm16    = bus_io.if_id_instruc[15:0];
    assign imm_sext = {{(XLEN-IMMW){imm16[IMMW-1]}}, imm16};
    assign stall    = bus_io.iss_id_stall;

    // Instruction classification and redirect decision
    always_comb begin
        is_rtype    = 1'b0;
        is_jr       = 1'b0;
        is_j        = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_alui     = 1'b0;
        is_lw       = 1'b0;
        is_sw       = 1'b0;
        take_c      = 1'b0;
        selpctype_c = PC_BRANCH;

        is_rtype = (opcode == OP_RTYPE);
        is_jr    = is_rtype && (funct == FN_JR);
        is_j     = (opcode == OP_J);
        is_beq   = (opcode == OP_BEQ);
        is_bne   = (opcode == OP_BNE);
        is_alui  = (opcode[OPW-1:3] == 3'b001) && (opcode != OP_RSVD);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);

        legal_c   = is_rtype || is_j || is_beq || is_bne || is_alui || is_lw || is_sw;
        writes_c  = (is_rtype && !is_jr) || is_alui || is_lw;
        regs_eq_c = (bus_io.reg_id_dataa == bus_io.reg_id_datab);

        if ((state_q == RUN) && !stall) begin
            if ((is_beq && regs_eq_c) || (is_bne && !regs_eq_c)) begin
                take_c      = 1'b1;
                selpctype_c = PC_BRANCH;
            end else if (is_jr) begin
                take_c      = 1'b1;
                selpctype_c = PC_JR;
            end else if (is_j) begin
                take_c      = 1'b1;
                selpctype_c = PC_JUMP;
            end else if (!legal_c && TRAP_EN) begin
                take_c      = 1'b1;
                selpctype_c = PC_TRAP;
            end
        end
    end

    // Next bundle contents
    always_comb begin
        imedext_d  = imm_sext;
        regdest_d  = rt;
        valid_d    = 1'b0;
        writereg_d = 1'b0;

        if ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) begin
            imedext_d = {{(XLEN-IMMW){1'b0}}, imm16};
        end else if (opcode == OP_LUI) begin
            imedext_d = {imm16, {(XLEN-IMMW){1'b0}}};
        end

        if (is_rtype) begin
            regdest_d = rd;
        end

        valid_d    = (state_q == RUN) && legal_c;
        writereg_d = valid_d && writes_c && (regdest_d != '0);
    end

    // Squash FSM and Issue pipeline register; everything holds under Issue stall
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            valid_q    <= 1'b0;
            op_q       <= '0;
            funct_q    <= '0;
            rega_q     <= '0;
            regb_q     <= '0;
            imedext_q  <= '0;
            regdest_q  <= '0;
            writereg_q <= 1'b0;
        end else if (!stall) begin
            state_q    <= take_c ? SQUASH : RUN;
            valid_q    <= valid_d;
            op_q       <= opcode;
            funct_q    <= funct;
            rega_q     <= bus_io.reg_id_dataa;
            regb_q     <= bus_io.reg_id_datab;
            imedext_q  <= imedext_d;
            regdest_q  <= regdest_d;
            writereg_q <= writereg_d;
        end
    end

    assign bus_io.id_stall          = stall;
    assign bus_io.id_if_selpcsource = take_c;
    assign bus_io.id_if_selpctype   = selpctype_c;
    assign bus_io.id_if_pcimd2ext   = bus_io.if_id_nextpc + XLEN'(imm_sext << 2);
    assign bus_io.id_if_rega        = bus_io.reg_id_dataa;
    assign bus_io.id_if_pcindex     = {bus_io.if_id_nextpc[31:28], bus_io.if_id_instruc[25:0], 2'b00};
    assign bus_io.id_reg_addra      = rs;
    assign bus_io.id_reg_addrb      = rt;

    assign bus_io.id_iss_valid      = valid_q;
    assign bus_io.id_iss_op         = op_q;
    assign bus_io.id_iss_funct      = funct_q;
    assign bus_io.id_iss_rega       = rega_q;
    assign bus_io.id_iss_regb       = regb_q;
    assign bus_io.id_iss_imedext    = imedext_q;
    assign bus_io.id_iss_regdest    = regdest_q;
    assign bus_io.id_iss_writereg   = writereg_q;

endmodule
